// File: rtl/oled_pkg.sv
// Shared definitions for the PmodOLED SPI transmit path: FSM states,
// DC encodings and the default SCLK divider.
package oled_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOW,
        ST_HIGH,
        ST_GAP
    } oled_state_t;

    localparam logic OLED_CMD  = 1'b0;
    localparam logic OLED_DATA = 1'b1;

    localparam int OLED_CLK_DIV_DEFAULT = 16;

endpackage

// File: rtl/oled_byte_fifo.sv
// Small synchronous FIFO holding {dc, data} entries for the SPI byte transmitter.
// Read data is the head entry (first-word fall-through) so a pop can latch it directly.
module oled_byte_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 9
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr_reg];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= wr_data;
    end

endmodule

// File: rtl/oled_spi_byte_tx.sv
// Queues command/data bytes and shifts them MSB-first onto the PmodOLED
// 4-wire SPI pins, with CS released for one divider phase after each byte.
module oled_spi_byte_tx
    import oled_pkg::*;
#(
    parameter int CLK_DIV    = OLED_CLK_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       WR_EN,
    input  logic [7:0] WR_DATA,
    input  logic       WR_DC,
    output logic       WR_RDY,
    output logic       BUSY,
    output logic       BYTE_DONE,
    output logic       CS,
    output logic       SDO,
    output logic       SCLK,
    output logic       DC
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    oled_state_t      state_reg;
    logic [DIV_W-1:0] div_cnt_reg;
    logic [2:0]       bit_cnt_reg;
    logic [7:0]       sr_reg;
    logic             cs_reg;
    logic             sclk_reg;
    logic             sdo_reg;
    logic             dc_reg;
    logic             byte_done_reg;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [8:0]       fifo_rd;
    logic [CNT_W-1:0] fifo_count;
    logic             phase_end;

    assign fifo_push = WR_EN && !fifo_full;
    assign fifo_pop  = (state_reg == ST_IDLE) && !fifo_empty;
    assign phase_end = (div_cnt_reg == DIV_LAST);

    oled_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (9)
    ) u_fifo (
        .clk     (CLK),
        .srst    (RST),
        .push    (fifo_push),
        .wr_data ({WR_DC, WR_DATA}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Outputs are loaded on the edge that enters each state, so SDO and DC
    // only ever move on entry to SETUP or LOW while SCLK is low or idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= ST_IDLE;
            div_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            sr_reg        <= '0;
            cs_reg        <= 1'b1;
            sclk_reg      <= 1'b1;
            sdo_reg       <= 1'b0;
            dc_reg        <= OLED_CMD;
            byte_done_reg <= 1'b0;
        end else begin
            byte_done_reg <= 1'b0;
            if (state_reg != ST_IDLE) begin
                div_cnt_reg <= phase_end ? '0 : div_cnt_reg + 1'b1;
            end
            unique case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        sr_reg    <= fifo_rd[7:0];
                        dc_reg    <= fifo_rd[8];
                        sdo_reg   <= fifo_rd[7];
                        cs_reg    <= 1'b0;
                        state_reg <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (phase_end) begin
                        bit_cnt_reg <= 3'd7;
                        sclk_reg    <= 1'b0;
                        sdo_reg     <= sr_reg[7];
                        state_reg   <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (phase_end) begin
                        sclk_reg  <= 1'b1;
                        state_reg <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (phase_end) begin
                        if (bit_cnt_reg == 3'd0) begin
                            cs_reg    <= 1'b1;
                            state_reg <= ST_GAP;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg - 3'd1;
                            sclk_reg    <= 1'b0;
                            sdo_reg     <= sr_reg[bit_cnt_reg - 3'd1];
                            state_reg   <= ST_LOW;
                        end
                    end
                end
                ST_GAP: begin
                    if (phase_end) begin
                        byte_done_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign WR_RDY    = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign BUSY      = !fifo_empty || (state_reg != ST_IDLE);
    assign BYTE_DONE = byte_done_reg;
    assign CS        = cs_reg;
    assign SDO       = sdo_reg;
    assign SCLK      = sclk_reg;
    assign DC        = dc_reg;

endmodule
